// File: rtl/ddram_byte_port_if.sv
// DDRAM Avalon-style bus between the byte port (master) and the HPS DDR3 controller (slave).
interface ddram_byte_port_if;
    logic        DDRAM_CLK;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;

    modport master (
        output DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE,
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
    );

    modport slave (
        input  DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE,
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
    );
endinterface

// File: rtl/ddram_byte_port.sv
// Byte-wide read/write port onto the 64-bit DDRAM bus with a single 8-byte line read cache.
module ddram_byte_port #(
    parameter logic [28:0] BASE_WORD = 29'h0600_0000
) (
    input  logic        clk21m,
    input  logic        reset,
    input  logic [27:0] addr,
    input  logic        rd,
    input  logic        we,
    input  logic [7:0]  din,
    input  logic        flush,
    output logic [7:0]  dout,
    output logic        ready,
    ddram_byte_port_if.master ddram
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ
    } state_t;

    state_t      state;
    logic [27:0] a_q;
    logic [7:0]  din_q;
    logic [63:0] line;
    logic [24:0] tag;
    logic        valid;
    logic        flushed;
    logic        rd_cmd;
    logic        we_cmd;
    logic [7:0]  be;

    assign ddram.DDRAM_CLK      = clk21m;
    assign ddram.DDRAM_BURSTCNT = 8'd1;
    assign ddram.DDRAM_ADDR     = BASE_WORD + {4'b0000, a_q[27:3]};
    assign ddram.DDRAM_RD       = rd_cmd;
    assign ddram.DDRAM_WE       = we_cmd;
    assign ddram.DDRAM_BE       = be;
    assign ddram.DDRAM_DIN      = {8{din_q}};

    always_ff @(posedge clk21m or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            ready   <= 1'b0;
            dout    <= '0;
            a_q     <= '0;
            din_q   <= '0;
            line    <= '0;
            tag     <= '0;
            valid   <= 1'b0;
            flushed <= 1'b0;
            rd_cmd  <= 1'b0;
            we_cmd  <= 1'b0;
            be      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (rd || we) begin
                        a_q   <= addr;
                        din_q <= din;
                        ready <= 1'b0;
                        if (we) begin
                            we_cmd <= 1'b1;
                            be     <= 8'b1 << addr[2:0];
                            state  <= S_WR_REQ;
                        end else if (valid && !flush && tag == addr[27:3]) begin
                            state <= S_HIT;
                        end else begin
                            rd_cmd  <= 1'b1;
                            flushed <= 1'b0;
                            state   <= S_RD_REQ;
                        end
                    end
                end
                S_HIT: begin
                    dout  <= line[{a_q[2:0], 3'b000} +: 8];
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                S_RD_REQ: begin
                    if (flush) flushed <= 1'b1;
                    if (!ddram.DDRAM_BUSY) begin
                        rd_cmd <= 1'b0;
                        state  <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // A flush seen while the fetch was in flight keeps the returning line uncached.
                    if (ddram.DDRAM_DOUT_READY) begin
                        line  <= ddram.DDRAM_DOUT;
                        tag   <= a_q[27:3];
                        valid <= !flushed;
                        dout  <= ddram.DDRAM_DOUT[{a_q[2:0], 3'b000} +: 8];
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else if (flush) begin
                        flushed <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    if (!ddram.DDRAM_BUSY) begin
                        we_cmd <= 1'b0;
                        be     <= '0;
                        if (valid && tag == a_q[27:3]) line[{a_q[2:0], 3'b000} +: 8] <= din_q;
                        ready  <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (flush) valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ddram_byte_port.sv
// Directed bench for ddram_byte_port: misses, hits, writes, busy stalls, flush and mid-transaction reset.
module tb_ddram_byte_port;
    logic        clk21m = 1'b0;
    logic        reset  = 1'b1;
    logic [27:0] addr   = '0;
    logic        rd     = 1'b0;
    logic        we     = 1'b0;
    logic [7:0]  din    = '0;
    logic        flush  = 1'b0;
    logic [7:0]  dout;
    logic        ready;

    int checks = 0;
    int passed = 0;
    int rd_acc = 0;
    int we_acc = 0;
    int both_cmd = 0;
    int stable;

    ddram_byte_port_if bus ();

    ddram_byte_port #(.BASE_WORD(29'h0600_0000)) dut (
        .clk21m(clk21m),
        .reset (reset),
        .addr  (addr),
        .rd    (rd),
        .we    (we),
        .din   (din),
        .flush (flush),
        .dout  (dout),
        .ready (ready),
        .ddram (bus.master)
    );

    always #5 clk21m = ~clk21m;

    always @(posedge clk21m) begin
        if (bus.DDRAM_RD && !bus.DDRAM_BUSY) rd_acc++;
        if (bus.DDRAM_WE && !bus.DDRAM_BUSY) we_acc++;
        if (bus.DDRAM_RD && bus.DDRAM_WE) both_cmd++;
    end

    // Drive one request for a single cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic r, input logic w, input logic [27:0] a, input logic [7:0] d);
        rd = r; we = w; addr = a; din = d;
        @(negedge clk21m);
        rd = 1'b0; we = 1'b0;
        addr = 28'h0AAAAAA; din = 8'hEE;
    endtask

    task automatic test_reset;
        @(negedge clk21m);
        checks++; if (ready !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", ready); else passed++;
        checks++; if (dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", dout); else passed++;
        checks++; if (bus.DDRAM_RD !== 1'b0 || bus.DDRAM_WE !== 1'b0)
            $display("FAIL reset_cmd got rd=%0b we=%0b exp 0/0", bus.DDRAM_RD, bus.DDRAM_WE); else passed++;
        checks++; if (bus.DDRAM_BE !== 8'h00) $display("FAIL reset_be got=%h exp=00", bus.DDRAM_BE); else passed++;
        checks++; if (bus.DDRAM_BURSTCNT !== 8'd1) $display("FAIL burstcnt got=%0d exp=1", bus.DDRAM_BURSTCNT); else passed++;
        reset = 1'b0;
        @(negedge clk21m);
        checks++; if (ready !== 1'b1) $display("FAIL ready_after_reset got=%0b exp=1", ready); else passed++;
    endtask

    task automatic test_read_miss;
        rd_acc = 0;
        issue(1'b1, 1'b0, 28'h0000010, 8'h00);
        checks++; if (bus.DDRAM_RD !== 1'b1 || ready !== 1'b0)
            $display("FAIL miss_cmd got rd=%0b ready=%0b exp rd=1 ready=0", bus.DDRAM_RD, ready); else passed++;
        checks++; if (bus.DDRAM_ADDR !== 29'h6000002) $display("FAIL miss_addr got=%h exp=6000002", bus.DDRAM_ADDR); else passed++;
        @(negedge clk21m);
        bus.DDRAM_DOUT = 64'h8877665544332211;
        bus.DDRAM_DOUT_READY = 1'b1;
        @(negedge clk21m);
        bus.DDRAM_DOUT_READY = 1'b0;
        checks++; if (ready !== 1'b1 || dout !== 8'h11)
            $display("FAIL miss_data got ready=%0b dout=%h exp ready=1 dout=11", ready, dout); else passed++;
        checks++; if (rd_acc !== 1) $display("FAIL miss_rd_pulses got=%0d exp=1", rd_acc); else passed++;
    endtask

    task automatic test_read_hit;
        rd_acc = 0;
        issue(1'b1, 1'b0, 28'h0000015, 8'h00);
        checks++; if (ready !== 1'b0) $display("FAIL hit_busy got ready=%0b exp=0", ready); else passed++;
        @(negedge clk21m);
        checks++; if (ready !== 1'b1 || dout !== 8'h66)
            $display("FAIL hit_data got ready=%0b dout=%h exp ready=1 dout=66", ready, dout); else passed++;
        checks++; if (rd_acc !== 0) $display("FAIL hit_no_rd got=%0d exp=0", rd_acc); else passed++;
    endtask

    task automatic test_write;
        rd_acc = 0; we_acc = 0;
        issue(1'b0, 1'b1, 28'h0000013, 8'hAB);
        checks++; if (bus.DDRAM_WE !== 1'b1 || bus.DDRAM_RD !== 1'b0)
            $display("FAIL wr_cmd got we=%0b rd=%0b exp we=1 rd=0", bus.DDRAM_WE, bus.DDRAM_RD); else passed++;
        checks++; if (bus.DDRAM_BE !== 8'b0000_1000) $display("FAIL wr_be got=%b exp=00001000", bus.DDRAM_BE); else passed++;
        checks++; if (bus.DDRAM_DIN !== 64'hABABABABABABABAB) $display("FAIL wr_din got=%h exp=abababababababab", bus.DDRAM_DIN); else passed++;
        checks++; if (bus.DDRAM_ADDR !== 29'h6000002) $display("FAIL wr_addr got=%h exp=6000002", bus.DDRAM_ADDR); else passed++;
        @(negedge clk21m);
        checks++; if (bus.DDRAM_WE !== 1'b0 || ready !== 1'b1 || we_acc !== 1)
            $display("FAIL wr_done got we=%0b ready=%0b n=%0d exp 0/1/1", bus.DDRAM_WE, ready, we_acc); else passed++;
        issue(1'b1, 1'b0, 28'h0000013, 8'h00);
        @(negedge clk21m);
        checks++; if (ready !== 1'b1 || dout !== 8'hAB || rd_acc !== 0)
            $display("FAIL wr_readback got ready=%0b dout=%h rd=%0d exp 1/ab/0", ready, dout, rd_acc); else passed++;
    endtask

    task automatic test_busy_miss;
        rd_acc = 0; stable = 0;
        bus.DDRAM_BUSY = 1'b1;
        issue(1'b1, 1'b0, 28'h0000100, 8'h00);
        for (int i = 0; i < 6; i++) begin
            if (bus.DDRAM_RD === 1'b1 && bus.DDRAM_ADDR === 29'h6000020) stable++;
            if (i == 5) bus.DDRAM_BUSY = 1'b0;
            @(negedge clk21m);
        end
        checks++; if (stable !== 6) $display("FAIL busy_stable got=%0d exp=6", stable); else passed++;
        checks++; if (bus.DDRAM_RD !== 1'b0 || rd_acc !== 1)
            $display("FAIL busy_single got rd=%0b n=%0d exp 0/1", bus.DDRAM_RD, rd_acc); else passed++;
        bus.DDRAM_DOUT = 64'h0102030405060708;
        bus.DDRAM_DOUT_READY = 1'b1;
        @(negedge clk21m);
        bus.DDRAM_DOUT_READY = 1'b0;
        checks++; if (ready !== 1'b1 || dout !== 8'h08)
            $display("FAIL busy_data got ready=%0b dout=%h exp 1/08", ready, dout); else passed++;
    endtask

    task automatic test_rd_we_both;
        rd_acc = 0; we_acc = 0;
        issue(1'b1, 1'b1, 28'h0000020, 8'h5A);
        checks++; if (bus.DDRAM_WE !== 1'b1 || bus.DDRAM_RD !== 1'b0)
            $display("FAIL both_cmd got we=%0b rd=%0b exp 1/0", bus.DDRAM_WE, bus.DDRAM_RD); else passed++;
        @(negedge clk21m);
        checks++; if (ready !== 1'b1 || rd_acc !== 0 || we_acc !== 1)
            $display("FAIL both_done got ready=%0b rd=%0d we=%0d exp 1/0/1", ready, rd_acc, we_acc); else passed++;
    endtask

    task automatic test_flush;
        rd_acc = 0;
        issue(1'b1, 1'b0, 28'h0000100, 8'h00);
        @(negedge clk21m);
        checks++; if (dout !== 8'h08 || rd_acc !== 0)
            $display("FAIL preflush_hit got dout=%h rd=%0d exp 08/0", dout, rd_acc); else passed++;
        flush = 1'b1;
        @(negedge clk21m);
        flush = 1'b0;
        issue(1'b1, 1'b0, 28'h0000100, 8'h00);
        checks++; if (bus.DDRAM_RD !== 1'b1) $display("FAIL flush_miss got rd=%0b exp=1", bus.DDRAM_RD); else passed++;
        @(negedge clk21m);
        bus.DDRAM_DOUT = 64'h1112131415161718;
        bus.DDRAM_DOUT_READY = 1'b1;
        @(negedge clk21m);
        bus.DDRAM_DOUT_READY = 1'b0;
        checks++; if (ready !== 1'b1 || dout !== 8'h18 || rd_acc !== 1)
            $display("FAIL flush_refill got ready=%0b dout=%h rd=%0d exp 1/18/1", ready, dout, rd_acc); else passed++;
    endtask

    task automatic test_reset_mid;
        issue(1'b1, 1'b0, 28'h0000010, 8'h00);
        @(negedge clk21m);
        reset = 1'b1;
        #1;
        checks++; if (bus.DDRAM_RD !== 1'b0 || ready !== 1'b0 || dout !== 8'h00)
            $display("FAIL mid_reset got rd=%0b ready=%0b dout=%h exp 0/0/00", bus.DDRAM_RD, ready, dout); else passed++;
        @(negedge clk21m);
        reset = 1'b0;
        bus.DDRAM_DOUT = 64'hCCCCCCCCCCCCCCCC;
        bus.DDRAM_DOUT_READY = 1'b1;
        @(negedge clk21m);
        bus.DDRAM_DOUT_READY = 1'b0;
        checks++; if (ready !== 1'b1 || dout !== 8'h00)
            $display("FAIL stale_ignored got ready=%0b dout=%h exp 1/00", ready, dout); else passed++;
        rd_acc = 0;
        issue(1'b1, 1'b0, 28'h0000010, 8'h00);
        checks++; if (bus.DDRAM_RD !== 1'b1) $display("FAIL post_reset_miss got rd=%0b exp=1", bus.DDRAM_RD); else passed++;
        @(negedge clk21m);
        bus.DDRAM_DOUT = 64'h8877665544332211;
        bus.DDRAM_DOUT_READY = 1'b1;
        @(negedge clk21m);
        bus.DDRAM_DOUT_READY = 1'b0;
        checks++; if (ready !== 1'b1 || dout !== 8'h11 || rd_acc !== 1)
            $display("FAIL post_reset_data got ready=%0b dout=%h rd=%0d exp 1/11/1", ready, dout, rd_acc); else passed++;
    endtask

    initial begin
        bus.DDRAM_BUSY = 1'b0;
        bus.DDRAM_DOUT = '0;
        bus.DDRAM_DOUT_READY = 1'b0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write();
        test_busy_miss();
        test_rd_we_both();
        test_flush();
        test_reset_mid();
        checks++; if (both_cmd !== 0) $display("FAIL rd_we_exclusive got=%0d exp=0", both_cmd); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
